wdt_cnt_ctrl: RTL and testbench
===============================

Name: wdt_cnt_ctrl

Overview:
Watchdog counter controller. It consumes the single-pclk tick pulse from the timebase divider and down-counts a loadable value. It sequences the watchdog through enable, feed, first timeout (interrupt) and second timeout (system reset request). It sits between the APB register block, which supplies control and reload, and the interrupt and reset outputs of the watchdog.

Parameters:
CNT_W, 16, width of the reload value and the down-counter.

Ports:
pclk  input  1  APB clock; all logic on its rising edge
presetn  input  1  asynchronous active-low reset
cnt_tick  input  1  timebase tick; one-pclk-wide pulse from the divider
wdt_en  input  1  level; watchdog enable
reload_val  input  CNT_W  value loaded into the counter
feed  input  1  one-cycle pulse; reloads the counter
intr_clr  input  1  one-cycle pulse; clears the interrupt and reloads the counter
rst_en  input  1  level; allows a second timeout to raise wdt_rst
cnt_val  output  CNT_W  current counter value, registered
wdt_intr  output  1  timeout interrupt, registered, level
wdt_rst  output  1  system reset request, registered, sticky
wdt_state  output  2  current FSM state, for status readback

Behaviour:
- Reset is asynchronous and active-low. On reset: wdt_state=IDLE, cnt_val=0, wdt_intr=0, wdt_rst=0. Assertion mid-operation aborts any state immediately.
- States: IDLE=2'b00, COUNT=2'b01, INTR=2'b10, RESET=2'b11.
- IDLE:
  - Counter holds its value and cnt_tick is ignored.
  - wdt_en=1 → cnt_val<=reload_val and the state moves to COUNT. A tick in that same cycle is ignored.
- COUNT, on a cnt_tick cycle:
  - If cnt_val!=0: cnt_val<=cnt_val-1.
  - If cnt_val==0 (timeout): wdt_intr<=1, cnt_val<=reload_val, state moves to INTR.
  - Timeout period is therefore reload_val+1 ticks. reload_val=0 gives a timeout on every tick.
- INTR, on a cnt_tick cycle:
  - If cnt_val!=0: decrement.
  - If cnt_val==0 and rst_en=1: wdt_rst<=1, state moves to RESET, cnt_val holds 0.
  - If cnt_val==0 and rst_en=0: cnt_val<=reload_val, stay in INTR, wdt_intr stays 1.
- RESET:
  - wdt_rst=1 and cnt_val is frozen.
  - wdt_en, feed, intr_clr and cnt_tick are all ignored.
  - Exit only via presetn.
- feed (COUNT or INTR): cnt_val<=reload_val. State and wdt_intr are unchanged. Ignored in IDLE and RESET.
- intr_clr (COUNT or INTR): wdt_intr<=0 and cnt_val<=reload_val. From INTR the state moves to COUNT. Ignored in IDLE and RESET.
- wdt_en=0 in COUNT or INTR: state moves to IDLE, wdt_intr<=0, cnt_val holds.
- Same-cycle priority, highest first: wdt_en=0 > intr_clr > feed > cnt_tick. A reload always wins over a decrement or timeout in the same cycle.
- Latency: every output is registered and updates on the edge that samples the event. An event at edge N is visible after edge N.
- Arithmetic: unsigned CNT_W. The decrement never wraps because zero is handled as timeout.
- Decode: wdt_state drives the FSM encoding directly. The FSM has no other states; unreachable encodings do not exist.
- reload_val is sampled only at load or reload instants. Changing it mid-count does not affect the current count.

Test Plan:
- Reset then enable: presetn low, then high; wdt_en=1, reload_val=3, tick every 4 pclk → cnt_val goes 3,2,1,0; wdt_intr=1 and cnt_val=3 after the 4th tick; wdt_state=INTR.
- Second timeout with rst_en=1: continue from the previous case for 4 more ticks → wdt_rst=1, wdt_state=RESET, cnt_val=0. Further feed, intr_clr or wdt_en=0 has no effect. Asserting presetn low returns all outputs to 0.
- Second timeout with rst_en=0: 4 more ticks in INTR → cnt_val reloads to 3, wdt_intr remains 1, wdt_rst=0.
- Feed versus tick collision: reload_val=5, cnt_val=1, feed and cnt_tick in the same cycle → cnt_val=5, no decrement. A later feed at cnt_val=0 prevents the timeout.
- Interrupt clear: in INTR with cnt_val=2, pulse intr_clr → wdt_intr=0, cnt_val=reload_val, wdt_state=COUNT.
- Disable and edge values: wdt_en=0 in INTR at cnt_val=7 → IDLE, wdt_intr=0, cnt_val=7 held through ticks. Re-enable with reload_val=0 → a timeout on the first tick. Re-enable with reload_val=16'hFFFF → no timeout before 65536 ticks.

Source files
------------

// File: rtl/wdt_cnt_ctrl.sv
// Watchdog counter controller: down-counts timebase ticks from a reload value,
// raising an interrupt on the first timeout and a sticky reset request on the second.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | watchdog disabled, counter holds, ticks ignored
// ST_COUNT | counting toward the first timeout
// ST_INTR  | first timeout seen, wdt_intr asserted, counting toward second
// ST_RESET | second timeout seen, wdt_rst asserted, frozen until presetn
module wdt_cnt_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             cnt_tick,
   input  logic             wdt_en,
   input  logic [CNT_W-1:0] reload_val,
   input  logic             feed,
   input  logic             intr_clr,
   input  logic             rst_en,
   output logic [CNT_W-1:0] cnt_val,
   output logic             wdt_intr,
   output logic             wdt_rst,
   output logic [1:0]       wdt_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01,
      ST_INTR  = 2'b10,
      ST_RESET = 2'b11
   } state_t;

   state_t state;
   logic   cnt_tc;

   assign cnt_tc    = (cnt_val == '0);
   assign wdt_state = state;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state    <= ST_IDLE;
         cnt_val  <= '0;
         wdt_intr <= 1'b0;
         wdt_rst  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wdt_en) begin
                  cnt_val <= reload_val;
                  state   <= ST_COUNT;
               end
            end
            ST_COUNT, ST_INTR: begin
               // Priority: disable > interrupt clear > feed > tick
               if (!wdt_en) begin
                  wdt_intr <= 1'b0;
                  state    <= ST_IDLE;
               end else if (intr_clr) begin
                  wdt_intr <= 1'b0;
                  cnt_val  <= reload_val;
                  state    <= ST_COUNT;
               end else if (feed) begin
                  cnt_val <= reload_val;
               end else if (cnt_tick) begin
                  if (!cnt_tc) begin
                     cnt_val <= cnt_val - CNT_W'(1);
                  end else if (state == ST_COUNT) begin
                     wdt_intr <= 1'b1;
                     cnt_val  <= reload_val;
                     state    <= ST_INTR;
                  end else if (rst_en) begin
                     wdt_rst <= 1'b1;
                     state   <= ST_RESET;
                  end else begin
                     cnt_val <= reload_val;
                  end
               end
            end
            ST_RESET: begin
               // Only presetn leaves this state
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wdt_cnt_ctrl.sv
// Directed bench for wdt_cnt_ctrl: hand-computed expectations for timeout
// sequencing, feed/clear priority, disable behaviour and counter edge values.
module tb_wdt_cnt_ctrl;

   localparam int CNT_W = 16;
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_COUNT = 2'b01;
   localparam logic [1:0] S_INTR  = 2'b10;
   localparam logic [1:0] S_RESET = 2'b11;

   logic             pclk = 1'b0;
   logic             presetn;
   logic             cnt_tick;
   logic             wdt_en;
   logic [CNT_W-1:0] reload_val;
   logic             feed;
   logic             intr_clr;
   logic             rst_en;
   logic [CNT_W-1:0] cnt_val;
   logic             wdt_intr;
   logic             wdt_rst;
   logic [1:0]       wdt_state;

   int n_vec = 0;
   int n_err = 0;

   wdt_cnt_ctrl #(.CNT_W(CNT_W)) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .cnt_tick   (cnt_tick),
      .wdt_en     (wdt_en),
      .reload_val (reload_val),
      .feed       (feed),
      .intr_clr   (intr_clr),
      .rst_en     (rst_en),
      .cnt_val    (cnt_val),
      .wdt_intr   (wdt_intr),
      .wdt_rst    (wdt_rst),
      .wdt_state  (wdt_state)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] st, input logic [CNT_W-1:0] cnt,
                          input logic intr, input logic rst);
      chk({tag, ".state"}, 32'(wdt_state), 32'(st));
      chk({tag, ".cnt"},   32'(cnt_val),   32'(cnt));
      chk({tag, ".intr"},  32'(wdt_intr),  32'(intr));
      chk({tag, ".rst"},   32'(wdt_rst),   32'(rst));
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   // One tick pulse, then idle to give a tick every 4 pclk
   task automatic tick();
      cnt_tick = 1'b1;
      cyc();
      cnt_tick = 1'b0;
      repeat (3) cyc();
   endtask

   initial begin
      presetn    = 1'b0;
      cnt_tick   = 1'b0;
      wdt_en     = 1'b0;
      reload_val = '0;
      feed       = 1'b0;
      intr_clr   = 1'b0;
      rst_en     = 1'b0;
      repeat (3) cyc();
      chk_all("reset", S_IDLE, 16'd0, 1'b0, 1'b0);

      // Enable with reload 3, first timeout after 4 ticks
      presetn    = 1'b1;
      reload_val = 16'd3;
      rst_en     = 1'b1;
      cyc();
      chk_all("idle_no_en", S_IDLE, 16'd0, 1'b0, 1'b0);
      wdt_en = 1'b1;
      cyc();
      chk_all("enable", S_COUNT, 16'd3, 1'b0, 1'b0);
      tick(); chk("cnt_t1", 32'(cnt_val), 32'd2);
      tick(); chk("cnt_t2", 32'(cnt_val), 32'd1);
      tick(); chk("cnt_t3", 32'(cnt_val), 32'd0);
      tick(); chk_all("timeout1", S_INTR, 16'd3, 1'b1, 1'b0);

      // Second timeout with rst_en=1
      repeat (3) tick();
      chk_all("intr_cnt0", S_INTR, 16'd0, 1'b1, 1'b0);
      tick();
      chk_all("timeout2", S_RESET, 16'd0, 1'b1, 1'b1);
      feed = 1'b1; cyc(); feed = 1'b0;
      intr_clr = 1'b1; cyc(); intr_clr = 1'b0;
      wdt_en = 1'b0; tick(); tick();
      chk_all("reset_frozen", S_RESET, 16'd0, 1'b1, 1'b1);
      presetn = 1'b0;
      #1;
      chk_all("async_rst", S_IDLE, 16'd0, 1'b0, 1'b0);
      cyc();

      // Second timeout with rst_en=0 reloads and stays in INTR
      presetn = 1'b1;
      rst_en  = 1'b0;
      wdt_en  = 1'b1;
      cyc();
      chk_all("reenable", S_COUNT, 16'd3, 1'b0, 1'b0);
      repeat (4) tick();
      chk_all("timeout1b", S_INTR, 16'd3, 1'b1, 1'b0);
      repeat (4) tick();
      chk_all("no_rst_en", S_INTR, 16'd3, 1'b1, 1'b0);

      // Interrupt clear reloads with the value present at the clear
      tick();
      chk("intr_cnt2", 32'(cnt_val), 32'd2);
      reload_val = 16'd6;
      intr_clr = 1'b1; cyc(); intr_clr = 1'b0;
      chk_all("intr_clr", S_COUNT, 16'd6, 1'b0, 1'b0);

      // Feed colliding with tick: reload wins
      reload_val = 16'd5;
      repeat (5) tick();
      chk("pre_feed", 32'(cnt_val), 32'd1);
      feed = 1'b1; cnt_tick = 1'b1; cyc(); feed = 1'b0; cnt_tick = 1'b0;
      chk_all("feed_vs_tick", S_COUNT, 16'd5, 1'b0, 1'b0);
      repeat (5) tick();
      chk_all("cnt_zero", S_COUNT, 16'd0, 1'b0, 1'b0);
      feed = 1'b1; cyc(); feed = 1'b0;
      chk_all("feed_at_zero", S_COUNT, 16'd5, 1'b0, 1'b0);
      tick();
      chk_all("after_feed", S_COUNT, 16'd4, 1'b0, 1'b0);

      // Disable in INTR at cnt_val=7
      reload_val = 16'd7;
      feed = 1'b1; cyc(); feed = 1'b0;
      repeat (8) tick();
      chk_all("intr_at7", S_INTR, 16'd7, 1'b1, 1'b0);
      wdt_en = 1'b0; cyc();
      chk_all("disable", S_IDLE, 16'd7, 1'b0, 1'b0);
      repeat (3) tick();
      chk_all("idle_hold", S_IDLE, 16'd7, 1'b0, 1'b0);

      // reload_val=0: enabling tick ignored, timeout on first real tick
      reload_val = 16'd0;
      wdt_en = 1'b1; cnt_tick = 1'b1; cyc(); cnt_tick = 1'b0;
      chk_all("en_rel0", S_COUNT, 16'd0, 1'b0, 1'b0);
      tick();
      chk_all("rel0_timeout", S_INTR, 16'd0, 1'b1, 1'b0);
      wdt_en = 1'b0; intr_clr = 1'b1; feed = 1'b1; cyc();
      intr_clr = 1'b0; feed = 1'b0;
      chk_all("dis_beats_clr", S_IDLE, 16'd0, 1'b0, 1'b0);

      // reload_val=FFFF: 65535 ticks reach zero without timeout
      reload_val = 16'hFFFF;
      rst_en = 1'b1;
      wdt_en = 1'b1; cyc();
      chk_all("en_max", S_COUNT, 16'hFFFF, 1'b0, 1'b0);
      reload_val = 16'h1234;
      cnt_tick = 1'b1;
      repeat (65535) @(posedge pclk);
      #1;
      cnt_tick = 1'b0;
      chk_all("max_zero", S_COUNT, 16'd0, 1'b0, 1'b0);
      tick();
      chk_all("max_timeout", S_INTR, 16'h1234, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
